// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM plus I/O window bus target with programmable wait states.
module mem_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] address,
    input  logic        rw,
    input  logic [31:0] datao,
    output logic [31:0] data,
    output logic        ready,
    output logic        err,
    output logic [31:0] io_out
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int WW = $clog2(WAIT_STATES + 2);

    logic [1:0]    state, next_state;
    logic [WW-1:0] wcnt;
    logic [31:0]   addr_q, wd_q, cyc, txn;
    logic          rw_q;
    logic [31:0]   ram [2**ADDR_BITS];

    logic [31:0] ea, ewd, rdata;
    logic        erw, in_ram, io0, io1, io2, bad, enter_resp;

    // With zero wait states the access happens on the accepting edge, so the live inputs stand in for the latched copies.
    always_comb begin
        ea     = (state == IDLE) ? address : addr_q;
        erw    = (state == IDLE) ? rw : rw_q;
        ewd    = (state == IDLE) ? datao : wd_q;
        in_ram = (ea >> ADDR_BITS) == 32'd0;
        io0    = ea == IO_BASE;
        io1    = ea == IO_BASE + 32'd1;
        io2    = ea == IO_BASE + 32'd2;
        bad    = !(in_ram || io0 || io1 || io2);
        rdata  = in_ram ? ram[ea[ADDR_BITS-1:0]] : io0 ? io_out : io1 ? cyc : io2 ? txn : 32'd0;
        next_state = (state == IDLE) ? (req ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE) :
                     (state == WAIT) ? ((wcnt == WW'(1)) ? RESP : WAIT) : IDLE;
        enter_resp = (next_state == RESP) && (state != RESP);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wcnt   <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            rw_q   <= 1'b0;
            ready  <= 1'b0;
            data   <= '0;
            err    <= 1'b0;
            io_out <= '0;
            cyc    <= '0;
            txn    <= '0;
        end else begin
            state <= next_state;
            ready <= enter_resp;
            cyc   <= cyc + 32'd1;
            if (state == RESP) txn <= txn + 32'd1;
            if (state == IDLE && req) begin
                addr_q <= address;
                rw_q   <= rw;
                wd_q   <= datao;
                wcnt   <= WW'(WAIT_STATES);
            end
            if (state == WAIT) wcnt <= wcnt - WW'(1);
            if (enter_resp) begin
                if (erw) data <= rdata;
                else if (io0) io_out <= ewd;
                if (bad) err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enter_resp && !erw && in_ram) ram[ea[ADDR_BITS-1:0]] <= ewd;
    end
endmodule
